shader_sequencer: RTL

//   Sequences the circular shader instruction store (shift/load shift-register of NUM_INSTR bytes).
//   Per pixel: rotates the store exactly NUM_INSTR times so the core sees instructions 0..N-1 in

---
 rtl/shader_pkg.sv | 14 +
 rtl/shader_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/shader_pkg.sv
// Shared types and defaults for the shader instruction sequencer.
package shader_pkg;

  // Sequencer operating modes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    LOAD = 2'd2
  } seq_state_t;

  // Program length of the default instruction store
  localparam int DEFAULT_NUM_INSTR = 10;

endpackage

// File: rtl/shader_sequencer.sv
// Shader sequencer: drives the single shift port of the circular instruction
// store.  EXEC rotates the store once per instruction so a whole pixel ends
// with the store realigned.  LOAD streams a complete new program in from the
// host.  Execution has priority over loading in the cycle both are requested.
module shader_sequencer
  import shader_pkg::*;
#(
  parameter int NUM_INSTR = DEFAULT_NUM_INSTR,
  parameter int IDX_W     = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pixel_start_i,
  input  logic             load_valid_i,
  input  logic [7:0]       load_instr_i,
  output logic             load_ready_o,
  input  logic             clear_err_i,
  output logic             shift_o,
  output logic             load_o,
  output logic [7:0]       instr_o,
  output logic             exec_valid_o,
  output logic [IDX_W-1:0] instr_idx_o,
  output logic             done_o,
  output logic             load_done_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             r_overrun;
  logic             w_cnt_last;
  logic             w_handshake;
  logic             w_drop;

  // Shared counter reaching the final instruction/byte of a program
  assign w_cnt_last = (r_cnt == LAST_IDX);

  // Host byte accepted; a pixel request in IDLE steals the shift port
  assign load_ready_o = ((r_state == IDLE) && !pixel_start_i) || (r_state == LOAD);
  assign w_handshake  = load_valid_i && load_ready_o;

  // A request is dropped anywhere except IDLE or the final exec cycle
  assign w_drop = pixel_start_i &&
                  (((r_state == EXEC) && !w_cnt_last) || (r_state == LOAD));

  // Datapath to the store and status outputs
  assign exec_valid_o = (r_state == EXEC);
  assign instr_idx_o  = (r_state == EXEC) ? r_cnt : '0;
  assign done_o       = (r_state == EXEC) && w_cnt_last;
  assign load_o       = w_handshake;
  assign shift_o      = (r_state == EXEC) || w_handshake;
  assign instr_o      = load_instr_i;
  assign load_done_o  = w_handshake && w_cnt_last;
  assign busy_o       = (r_state != IDLE);
  assign overrun_o    = r_overrun;

  // State, shared counter and sticky overrun flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_err_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Next-state and counter update; a started load always runs to completion
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (pixel_start_i) begin
          w_state_nxt = EXEC;
          w_cnt_nxt   = '0;
        end else if (w_handshake) begin
          if (w_cnt_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = r_cnt + IDX_W'(1);
          end
        end
      end
      EXEC: begin
        if (w_cnt_last) begin
          w_state_nxt = pixel_start_i ? EXEC : IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + IDX_W'(1);
        end
      end
      LOAD: begin
        if (w_handshake) begin
          if (w_cnt_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
